// File: rtl/systolic_column_ws.sv
// Weight-stationary systolic column: ROWS MAC stages fed by a weight shift chain and skewed features.
// Optional ReLU on the column output when SYS_COL_RELU_EN is defined.
module systolic_column_ws #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int ACC_W = 2*WIDTH + $clog2(ROWS) + 2
) (
  input  logic                    clk_in1,
  input  logic                    nrst_in1,
  input  logic [WIDTH-1:0]        weight_in,
  input  logic                    weight_valid,
  output logic                    weight_ready,
  output logic [WIDTH-1:0]        weight_out,
  output logic                    weight_out_valid,
  input  logic [ROWS*WIDTH-1:0]   feat_in,
  input  logic [ACC_W-1:0]        psum_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ACC_W-1:0]        psum_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    weights_loaded,
  output logic                    busy
);

  localparam int CNT_W = $clog2(ROWS + 1);
  localparam int IF_W  = $clog2(ROWS + 2);

  typedef enum logic [1:0] {EMPTY, LOAD, READY, RUN} state_t;

  state_t                  r_state, w_stateNext;
  logic signed [WIDTH-1:0] r_w [ROWS];
  logic signed [WIDTH-1:0] r_skew [ROWS][ROWS];
  logic signed [ACC_W-1:0] r_acc [ROWS];
  logic [ROWS-1:0]         r_vld;
  logic [CNT_W-1:0]        r_beatCnt;
  logic [IF_W-1:0]         r_inflight;
  logic                    r_loaded;
  logic [WIDTH-1:0]        r_woHold;

  logic signed [WIDTH-1:0] w_feat [ROWS];
  logic signed [ACC_W-1:0] w_sum [ROWS];
  logic signed [ACC_W-1:0] w_outNext;
  logic                    w_weightReady, w_inReady;
  logic                    w_stall, w_accept, w_shift, w_handshake, w_lastBeat;

  assign w_stall     = r_vld[ROWS-1] && !out_ready;
  assign w_handshake = r_vld[ROWS-1] && out_ready;
  assign w_accept    = in_valid && w_inReady;
  assign w_shift     = weight_valid && w_weightReady;
  assign w_lastBeat  = (r_state == LOAD) && (r_beatCnt == CNT_W'(ROWS - 1));

  always_ff @(posedge clk_in1) begin
    if (!nrst_in1) r_state <= EMPTY;
    else           r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext   = r_state;
    w_weightReady = 1'b0;
    w_inReady     = 1'b0;
    case (r_state)
      EMPTY: begin
        w_weightReady = 1'b1;
        if (weight_valid) w_stateNext = LOAD;
      end
      LOAD: begin
        w_weightReady = 1'b1;
        if (weight_valid && w_lastBeat) w_stateNext = READY;
      end
      READY: begin
        // A pending weight beat takes priority over a feature vector.
        w_weightReady = 1'b1;
        w_inReady     = !weight_valid;
        if (weight_valid)  w_stateNext = LOAD;
        else if (in_valid) w_stateNext = RUN;
      end
      RUN: begin
        w_inReady = !w_stall;
        if (r_inflight == '0 && !w_accept) w_stateNext = READY;
      end
      default: w_stateNext = EMPTY;
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (!nrst_in1) begin
      r_beatCnt <= '0;
      r_loaded  <= 1'b0;
      r_woHold  <= '0;
      for (int i = 0; i < ROWS; i++) r_w[i] <= '0;
    end else if (w_shift) begin
      r_woHold <= r_w[ROWS-1];
      r_w[0]   <= $signed(weight_in);
      for (int i = 1; i < ROWS; i++) r_w[i] <= r_w[i-1];
      if (w_lastBeat) begin
        r_beatCnt <= '0;
        r_loaded  <= 1'b1;
      end else begin
        r_beatCnt <= r_beatCnt + 1'b1;
        r_loaded  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in1) begin
    if (!nrst_in1) begin
      r_inflight <= '0;
    end else if (w_accept && !w_handshake) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (!w_accept && w_handshake) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  genvar gi;
  for (gi = 0; gi < ROWS; gi++) begin : g_stage
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prev;
    if (gi == 0) begin : g_first
      assign w_feat[gi] = $signed(feat_in[WIDTH-1:0]);
      assign w_prev     = $signed(psum_in);
    end else begin : g_rest
      assign w_feat[gi] = r_skew[gi][gi-1];
      assign w_prev     = r_acc[gi-1];
    end
    assign w_prod     = r_w[gi] * w_feat[gi];
    assign w_sum[gi]  = $signed(w_prev + {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod});
  end

`ifdef SYS_COL_RELU_EN
  assign w_outNext = w_sum[ROWS-1][ACC_W-1] ? '0 : w_sum[ROWS-1];
`else
  assign w_outNext = w_sum[ROWS-1];
`endif

  // Skew, partial-sum and valid registers all freeze together while the output is stalled.
  always_ff @(posedge clk_in1) begin
    if (!nrst_in1) begin
      r_vld <= '0;
      for (int i = 0; i < ROWS; i++) begin
        r_acc[i] <= '0;
        for (int j = 0; j < ROWS; j++) r_skew[i][j] <= '0;
      end
    end else if (!w_stall) begin
      r_vld <= {r_vld[ROWS-2:0], w_accept};
      for (int i = 1; i < ROWS; i++) begin
        r_skew[i][0] <= $signed(feat_in[i*WIDTH +: WIDTH]);
        for (int j = 1; j < ROWS; j++) r_skew[i][j] <= r_skew[i][j-1];
      end
      for (int i = 0; i < ROWS - 1; i++) r_acc[i] <= w_sum[i];
      r_acc[ROWS-1] <= w_outNext;
    end
  end

  assign weight_ready     = w_weightReady;
  assign in_ready         = w_inReady;
  assign weight_out_valid = w_shift;
  assign weight_out       = w_shift ? r_w[ROWS-1] : r_woHold;
  assign psum_out         = r_acc[ROWS-1];
  assign out_valid        = r_vld[ROWS-1];
  assign weights_loaded   = r_loaded;
  assign busy             = (r_inflight != '0);

endmodule

// File: tb/tb_systolic_column_ws.sv
// Directed self-checking bench for systolic_column_ws (ROWS=4, WIDTH=8).
// Expected values are hand-computed from weights w0..w3 = 1,2,3,4 and then 127.
module tb_systolic_column_ws;

  localparam int WIDTH = 8;
  localparam int ROWS  = 4;
  localparam int ACC_W = 2*WIDTH + $clog2(ROWS) + 2;

`ifdef SYS_COL_RELU_EN
  localparam logic [ACC_W-1:0] EXP_EXT = '0;
`else
  localparam logic signed [ACC_W-1:0] EXP_EXT = -65024;
`endif

  logic                  clk = 1'b0;
  logic                  nrst;
  logic [WIDTH-1:0]      weight_in;
  logic                  weight_valid;
  logic                  weight_ready;
  logic [WIDTH-1:0]      weight_out;
  logic                  weight_out_valid;
  logic [ROWS*WIDTH-1:0] feat_in;
  logic [ACC_W-1:0]      psum_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [ACC_W-1:0]      psum_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  weights_loaded;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_column_ws #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
    .clk_in1(clk), .nrst_in1(nrst),
    .weight_in(weight_in), .weight_valid(weight_valid), .weight_ready(weight_ready),
    .weight_out(weight_out), .weight_out_valid(weight_out_valid),
    .feat_in(feat_in), .psum_in(psum_in), .in_valid(in_valid), .in_ready(in_ready),
    .psum_out(psum_out), .out_valid(out_valid), .out_ready(out_ready),
    .weights_loaded(weights_loaded), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROWS*WIDTH-1:0] packFeat(input int f0, input int f1, input int f2, input int f3);
    logic [ROWS*WIDTH-1:0] v;
    v[7:0]   = f0[7:0];
    v[15:8]  = f1[7:0];
    v[23:16] = f2[7:0];
    v[31:24] = f3[7:0];
    return v;
  endfunction

  task automatic sendVec(input logic [ROWS*WIDTH-1:0] f, input logic [ACC_W-1:0] p);
    feat_in  = f;
    psum_in  = p;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    nrst = 1'b0; weight_in = '0; weight_valid = 1'b0; feat_in = '0; psum_in = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0)      begin errors++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (weights_loaded !== 1'b0) begin errors++; $display("[TB] FAIL reset_loaded: got %0b want 0", weights_loaded); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (in_ready !== 1'b0)       begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (weight_ready !== 1'b1)   begin errors++; $display("[TB] FAIL reset_weight_ready: got %0b want 1", weight_ready); end
    checks++; if (psum_out !== '0)         begin errors++; $display("[TB] FAIL reset_psum_out: got %0d want 0", psum_out); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_load;
    logic [WIDTH-1:0] beats [4];
    beats = '{8'd4, 8'd3, 8'd2, 8'd1};
    for (int b = 0; b < 4; b++) begin
      weight_in = beats[b]; weight_valid = 1'b1;
      #1;
      checks++; if (weight_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL load_wov beat%0d: got %0b want 1", b, weight_out_valid); end
      tick();
      checks++;
      if (weights_loaded !== (b == 3)) begin
        errors++; $display("[TB] FAIL load_loaded beat%0d: got %0b want %0b", b, weights_loaded, (b == 3));
      end
    end
    weight_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single;
    int lat;
    feat_in = packFeat(1, 1, 1, 1); psum_in = '0; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_in_ready: got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    checks++; if (lat != 4)          begin errors++; $display("[TB] FAIL single_latency: got %0d want 4", lat); end
    checks++; if (psum_out !== 20'd10) begin errors++; $display("[TB] FAIL single_psum: got %0d want 10", $signed(psum_out)); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("[TB] FAIL single_busy: got %0b want 1", busy); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [ACC_W-1:0] exp [3];
    int n;
    exp = '{20'd15, 20'd7, 20'd1};
    sendVec(packFeat(1, 1, 1, 1), 20'd5);
    sendVec(packFeat(2, 0, 0, 0), 20'd5);
    sendVec(packFeat(0, 0, 0, -1), 20'd5);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1)  begin errors++; $display("[TB] FAIL b2b_valid%0d: got %0b want 1", k, out_valid); end
      checks++; if (psum_out !== exp[k]) begin errors++; $display("[TB] FAIL b2b_psum%0d: got %0d want %0d", k, $signed(psum_out), $signed(exp[k])); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %0b want 0", out_valid); end
    tick(); tick();
  endtask

  task automatic test_stall;
    logic [ACC_W-1:0] exp [3];
    int n, k;
    exp = '{20'd15, 20'd7, 20'd1};
    out_ready = 1'b0;
    sendVec(packFeat(1, 1, 1, 1), 20'd5);
    sendVec(packFeat(2, 0, 0, 0), 20'd5);
    sendVec(packFeat(0, 0, 0, -1), 20'd5);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    for (int s = 0; s < 3; s++) begin
      checks++; if (psum_out !== 20'd15) begin errors++; $display("[TB] FAIL stall_psum%0d: got %0d want 15", s, $signed(psum_out)); end
      checks++; if (in_ready !== 1'b0)   begin errors++; $display("[TB] FAIL stall_in_ready%0d: got %0b want 0", s, in_ready); end
      checks++; if (busy !== 1'b1)       begin errors++; $display("[TB] FAIL stall_busy%0d: got %0b want 1", s, busy); end
      tick();
    end
    out_ready = 1'b1;
    k = 0; n = 0;
    while (k < 3 && n < 20) begin
      if (out_valid) begin
        checks++; if (psum_out !== exp[k]) begin errors++; $display("[TB] FAIL stall_release%0d: got %0d want %0d", k, $signed(psum_out), $signed(exp[k])); end
        k++;
      end
      tick(); n++;
    end
    checks++; if (k != 3)             begin errors++; $display("[TB] FAIL stall_count: got %0d outputs want 3", k); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_dup: got %0b want 0", out_valid); end
    tick(); tick();
  endtask

  task automatic test_reload_during_run;
    logic [WIDTH-1:0] oldW [3];
    int n;
    bit seen;
    oldW = '{8'd3, 8'd2, 8'd1};
    sendVec(packFeat(1, 1, 1, 1), '0);
    in_valid = 1'b0;
    weight_in = 8'd127; weight_valid = 1'b1;
    #1;
    checks++; if (weight_ready !== 1'b0)     begin errors++; $display("[TB] FAIL reload_wready_run: got %0b want 0", weight_ready); end
    checks++; if (weight_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reload_wov_run: got %0b want 0", weight_out_valid); end
    n = 0; seen = 1'b0;
    while (!weight_ready && n < 20) begin
      if (out_valid) begin
        seen = 1'b1;
        checks++; if (psum_out !== 20'd10) begin errors++; $display("[TB] FAIL reload_run_psum: got %0d want 10", $signed(psum_out)); end
        checks++; if (weights_loaded !== 1'b1) begin errors++; $display("[TB] FAIL reload_run_loaded: got %0b want 1", weights_loaded); end
      end
      tick(); n++;
    end
    checks++; if (seen !== 1'b1)             begin errors++; $display("[TB] FAIL reload_run_output: got %0b want 1", seen); end
    checks++; if (weight_ready !== 1'b1)     begin errors++; $display("[TB] FAIL reload_drain_timeout: got %0b want 1", weight_ready); end
    checks++; if (weight_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL reload_wov_beat0: got %0b want 1", weight_out_valid); end
    checks++; if (weight_out !== 8'd4)       begin errors++; $display("[TB] FAIL reload_wout_beat0: got %0d want 4", weight_out); end
    checks++; if (in_ready !== 1'b0)         begin errors++; $display("[TB] FAIL reload_weight_wins: got %0b want 0", in_ready); end
    tick();
    checks++; if (weights_loaded !== 1'b0)   begin errors++; $display("[TB] FAIL reload_loaded_clear: got %0b want 0", weights_loaded); end
    for (int b = 0; b < 3; b++) begin
      checks++; if (weight_out !== oldW[b]) begin errors++; $display("[TB] FAIL reload_wout_beat%0d: got %0d want %0d", b + 1, weight_out, oldW[b]); end
      tick();
    end
    weight_valid = 1'b0;
    checks++; if (weights_loaded !== 1'b1)   begin errors++; $display("[TB] FAIL reload_loaded_set: got %0b want 1", weights_loaded); end
  endtask

  task automatic test_extreme;
    int n;
    sendVec(packFeat(-128, -128, -128, -128), '0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (out_valid !== 1'b1)  begin errors++; $display("[TB] FAIL extreme_timeout: got %0b want 1", out_valid); end
    checks++; if (psum_out !== EXP_EXT) begin errors++; $display("[TB] FAIL extreme_psum: got %0d want %0d", $signed(psum_out), $signed(EXP_EXT)); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_midstream;
    bit seenValid;
    sendVec(packFeat(1, 1, 1, 1), 20'd5);
    sendVec(packFeat(2, 0, 0, 0), 20'd5);
    in_valid = 1'b0;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    checks++; if (out_valid !== 1'b0)      begin errors++; $display("[TB] FAIL midrst_out_valid: got %0b want 0", out_valid); end
    checks++; if (weights_loaded !== 1'b0) begin errors++; $display("[TB] FAIL midrst_loaded: got %0b want 0", weights_loaded); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("[TB] FAIL midrst_busy: got %0b want 0", busy); end
    checks++; if (in_ready !== 1'b0)       begin errors++; $display("[TB] FAIL midrst_in_ready: got %0b want 0", in_ready); end
    checks++; if (weight_ready !== 1'b1)   begin errors++; $display("[TB] FAIL midrst_weight_ready: got %0b want 1", weight_ready); end
    seenValid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seenValid = 1'b1;
      tick();
    end
    checks++; if (seenValid !== 1'b0)      begin errors++; $display("[TB] FAIL midrst_partial_output: got %0b want 0", seenValid); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_single();
    test_back_to_back();
    test_stall();
    test_reload_during_run();
    test_extreme();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
